// File: rtl/block_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// block_sequencer_pkg
// Shared types and helpers for the multi-channel block write sequencer.
//   blk_seq_state_e : per-channel FSM state (BS_IDLE, BS_ACTIVE)
//   DROP_CNT_W      : width of the per-channel dropped-beat counter
//   blk_ptr_w()     : address width needed to index n entries ($clog2)
// -----------------------------------------------------------------------------
package block_sequencer_pkg;

    typedef enum logic [0:0] {
        BS_IDLE   = 1'b0,
        BS_ACTIVE = 1'b1
    } blk_seq_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int blk_ptr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/block_sequencer_channel.sv
// -----------------------------------------------------------------------------
// block_seq_channel
// One channel of the block sequencer: FSM, write pointer, latched block
// length, completed-block index, sticky error and optional drop counter.
//
// Optional feature macro: BLOCK_SEQ_DROP_CNT_EN
//   defined   -> 16-bit saturating count of beats dropped while idle
//   undefined -> no counter registers, drop_cnt tied to 0
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_block    start / restart request (priority over valid_in)
//   block_len      block length, sampled when start_block is accepted
//   auto_restart   stay active after a completed block
//   valid_in       input beat valid
//   clr_err        clear sticky error (and drop counter)
//   wr_en          beat accepted this cycle (combinational)
//   wr_ptr         write address for the current beat (registered)
//   block_done     one-cycle pulse the cycle after the last beat
//   block_idx      completed block count, wraps
//   busy           channel is active
//   err            sticky error: illegal length or beat dropped while idle
//   drop_cnt       dropped-beat counter
// -----------------------------------------------------------------------------
module block_seq_channel
    import block_sequencer_pkg::*;
#(
    parameter int BLOCK_SIZE_MAX = 256,
    parameter int BLK_IDX_W      = 16,
    parameter int PTR_W          = 8,
    parameter int LEN_W          = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_block,
    input  logic [LEN_W-1:0]      block_len,
    input  logic                  auto_restart,
    input  logic                  valid_in,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [PTR_W-1:0]      wr_ptr,
    output logic                  block_done,
    output logic [BLK_IDX_W-1:0]  block_idx,
    output logic                  busy,
    output logic                  err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BLOCK_SIZE_MAX);

    blk_seq_state_e         r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [LEN_W-1:0]       r_len_q;
    logic [BLK_IDX_W-1:0]   r_block_idx;
    logic                   r_block_done;
    logic                   r_err;

    logic                   w_active;
    logic                   w_len_ok;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_drop;
    logic                   w_err_event;

    assign w_active    = (r_state == BS_ACTIVE);
    assign w_len_ok    = (block_len != '0) && (block_len <= MAX_LEN);
    // A start request in the same cycle steals the beat, even the last one.
    assign w_accept    = w_active & valid_in & ~start_block;
    assign w_last      = (LEN_W'(r_ptr) == (r_len_q - LEN_W'(1)));
    assign w_drop      = ~w_active & valid_in;
    assign w_err_event = (start_block & ~w_len_ok) | w_drop;

    // Channel FSM with pointer, length and block index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BS_IDLE;
            r_ptr        <= '0;
            r_len_q      <= MAX_LEN;
            r_block_idx  <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= 1'b0;
            if (start_block) begin
                // Start or abort: pointer always rewinds, index untouched.
                r_ptr <= '0;
                if (w_len_ok) begin
                    r_len_q <= block_len;
                    r_state <= BS_ACTIVE;
                end else begin
                    r_state <= BS_IDLE;
                end
            end else if (w_accept) begin
                if (w_last) begin
                    r_ptr        <= '0;
                    r_block_idx  <= r_block_idx + BLK_IDX_W'(1);
                    r_block_done <= 1'b1;
                    if (!auto_restart) begin
                        r_state <= BS_IDLE;
                    end
                end else begin
                    r_ptr <= r_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Sticky error; a new error event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_event) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

`ifdef BLOCK_SEQ_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Saturating counter; a drop coinciding with a clear restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (clr_err) begin
                r_drop_cnt <= DROP_CNT_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end else if (clr_err) begin
            r_drop_cnt <= '0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign wr_en      = w_accept;
    assign wr_ptr     = r_ptr;
    assign block_done = r_block_done;
    assign block_idx  = r_block_idx;
    assign busy       = w_active;
    assign err        = r_err;

endmodule

// File: rtl/block_sequencer.sv
// -----------------------------------------------------------------------------
// block_sequencer
// NUM_CH independent block write sequencers between the datapath valid
// streams and the per-channel block memories. This level only slices the
// flattened buses and fans clr_err out to every channel.
//
// Optional feature macro: BLOCK_SEQ_DROP_CNT_EN (per-channel drop counter,
// see block_seq_channel). Port list is identical either way.
//
// Ports (per-channel fields packed channel 0 in the LSBs):
//   clk, rst_n    clock, asynchronous active-low reset
//   start_block   [NUM_CH]            start / restart request
//   block_len     [NUM_CH*LEN_W]      block length
//   auto_restart  [NUM_CH]            re-enter next block after done
//   valid_in      [NUM_CH]            input beat valid
//   clr_err       1                   clear all sticky errors
//   wr_en         [NUM_CH]            write strobe
//   wr_ptr        [NUM_CH*PTR_W]      write address
//   block_done    [NUM_CH]            block complete pulse
//   block_idx     [NUM_CH*BLK_IDX_W]  completed block count
//   busy          [NUM_CH]            channel active
//   err           [NUM_CH]            sticky error
//   drop_cnt      [NUM_CH*16]         dropped-beat counters
// -----------------------------------------------------------------------------
module block_sequencer
    import block_sequencer_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int BLOCK_SIZE_MAX = 256,
    parameter  int BLK_IDX_W      = 16,
    localparam int PTR_W          = blk_ptr_w(BLOCK_SIZE_MAX),
    localparam int LEN_W          = blk_ptr_w(BLOCK_SIZE_MAX + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              start_block,
    input  logic [NUM_CH*LEN_W-1:0]        block_len,
    input  logic [NUM_CH-1:0]              auto_restart,
    input  logic [NUM_CH-1:0]              valid_in,
    input  logic                           clr_err,
    output logic [NUM_CH-1:0]              wr_en,
    output logic [NUM_CH*PTR_W-1:0]        wr_ptr,
    output logic [NUM_CH-1:0]              block_done,
    output logic [NUM_CH*BLK_IDX_W-1:0]    block_idx,
    output logic [NUM_CH-1:0]              busy,
    output logic [NUM_CH-1:0]              err,
    output logic [NUM_CH*DROP_CNT_W-1:0]   drop_cnt
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        block_seq_channel #(
            .BLOCK_SIZE_MAX (BLOCK_SIZE_MAX),
            .BLK_IDX_W      (BLK_IDX_W),
            .PTR_W          (PTR_W),
            .LEN_W          (LEN_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .start_block  (start_block[gi]),
            .block_len    (block_len[gi*LEN_W +: LEN_W]),
            .auto_restart (auto_restart[gi]),
            .valid_in     (valid_in[gi]),
            .clr_err      (clr_err),
            .wr_en        (wr_en[gi]),
            .wr_ptr       (wr_ptr[gi*PTR_W +: PTR_W]),
            .block_done   (block_done[gi]),
            .block_idx    (block_idx[gi*BLK_IDX_W +: BLK_IDX_W]),
            .busy         (busy[gi]),
            .err          (err[gi]),
            .drop_cnt     (drop_cnt[gi*DROP_CNT_W +: DROP_CNT_W])
        );
    end

endmodule

// File: tb/tb_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_block_sequencer
// Scoreboarded bench: expected write pointers and done/index events are
// queued as stimulus is driven and retired by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_block_sequencer;

    localparam int NUM_CH = 4;
    localparam int BSM    = 256;
    localparam int IDX_W  = 16;
    localparam int PTR_W  = 8;
    localparam int LEN_W  = 9;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_CH-1:0]         start_block = '0;
    logic [NUM_CH*LEN_W-1:0]   block_len = '0;
    logic [NUM_CH-1:0]         auto_restart = '0;
    logic [NUM_CH-1:0]         valid_in = '0;
    logic                      clr_err = 1'b0;
    logic [NUM_CH-1:0]         wr_en;
    logic [NUM_CH*PTR_W-1:0]   wr_ptr;
    logic [NUM_CH-1:0]         block_done;
    logic [NUM_CH*IDX_W-1:0]   block_idx;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         err;
    logic [NUM_CH*16-1:0]      drop_cnt;

    block_sequencer #(
        .NUM_CH         (NUM_CH),
        .BLOCK_SIZE_MAX (BSM),
        .BLK_IDX_W      (IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_block  (start_block),
        .block_len    (block_len),
        .auto_restart (auto_restart),
        .valid_in     (valid_in),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .wr_ptr       (wr_ptr),
        .block_done   (block_done),
        .block_idx    (block_idx),
        .busy         (busy),
        .err          (err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int val;
    } exp_t;

    exp_t wr_q[$];
    exp_t done_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus on one channel; inputs return to idle afterwards.
    task automatic cyc(input int ch, input bit v, input bit st, input int len, input bit clr);
        if (st) begin
            start_block[ch] = 1'b1;
            block_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
        end
        valid_in[ch] = v;
        clr_err      = clr;
        @(posedge clk);
        #1;
        start_block = '0;
        valid_in    = '0;
        clr_err     = 1'b0;
    endtask

    task automatic push_wr(input int ch, input int p);
        exp_t e;
        e.ch = ch;
        e.val = p;
        wr_q.push_back(e);
    endtask

    task automatic push_done(input int ch, input int idx);
        exp_t e;
        e.ch = ch;
        e.val = idx;
        done_q.push_back(e);
    endtask

    // Monitor: every observed write strobe / done pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en[c]) begin
                    if (wr_q.size() > 0) begin
                        e = wr_q.pop_front();
                        chk("wr_ch", 64'(c), 64'(e.ch));
                        chk("wr_ptr", 64'(wr_ptr[c*PTR_W +: PTR_W]), 64'(e.val));
                        $display("wr   ch%0d ptr=%0d", c, wr_ptr[c*PTR_W +: PTR_W]);
                    end else begin
                        chk("wr_en_unexpected", 64'(wr_en[c]), 64'd0);
                    end
                end
                if (block_done[c]) begin
                    if (done_q.size() > 0) begin
                        e = done_q.pop_front();
                        chk("done_ch", 64'(c), 64'(e.ch));
                        chk("done_idx", 64'(block_idx[c*IDX_W +: IDX_W]), 64'(e.val));
                        $display("done ch%0d idx=%0d", c, block_idx[c*IDX_W +: IDX_W]);
                    end else begin
                        chk("done_unexpected", 64'(block_done[c]), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idx", block_idx, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(block_done), 64'd0);
        chk("rst_drop", drop_cnt, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- ch0: len 4, no restart ----------------
        cyc(0, 0, 1, 4, 0);
        chk("ch0_busy_start", 64'(busy[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            push_wr(0, i);
            if (i == 3) push_done(0, 1);
            cyc(0, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("ch0_idx", 64'(block_idx[0 +: IDX_W]), 64'd1);
        chk("ch0_busy_end", 64'(busy[0]), 64'd0);
        chk("ch0_err_before", 64'(err[0]), 64'd0);
        cyc(0, 1, 0, 0, 0);   // dropped beat
        chk("ch0_err_drop", 64'(err[0]), 64'd1);

        // ---------------- ch1: len 3, auto restart, gaps ----------------
        auto_restart[1] = 1'b1;
        cyc(1, 0, 1, 3, 0);
        for (int i = 0; i < 9; i++) begin
            push_wr(1, i % 3);
            if (i % 3 == 2) push_done(1, i / 3 + 1);
            cyc(1, 1, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
        end
        chk("ch1_idx", 64'(block_idx[IDX_W +: IDX_W]), 64'd3);
        chk("ch1_busy", 64'(busy[1]), 64'd1);
        chk("ch1_ptr", 64'(wr_ptr[PTR_W +: PTR_W]), 64'd0);

        // ---------------- ch2: len 1, back-to-back done ----------------
        auto_restart[2] = 1'b1;
        cyc(2, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            push_wr(2, 0);
            push_done(2, i + 1);
            cyc(2, 1, 0, 0, 0);
        end
        cyc(2, 0, 0, 0, 0);
        chk("ch2_idx", 64'(block_idx[2*IDX_W +: IDX_W]), 64'd5);
        chk("ch2_busy", 64'(busy[2]), 64'd1);

        // ---------------- ch3: abort with valid high ----------------
        cyc(3, 0, 1, 8, 0);
        for (int i = 0; i < 5; i++) begin
            push_wr(3, i);
            cyc(3, 1, 0, 0, 0);
        end
        cyc(3, 1, 1, 2, 0);   // abort: beat must not be accepted
        chk("ch3_ptr_abort", 64'(wr_ptr[3*PTR_W +: PTR_W]), 64'd0);
        chk("ch3_idx_abort", 64'(block_idx[3*IDX_W +: IDX_W]), 64'd0);
        for (int i = 0; i < 2; i++) begin
            push_wr(3, i);
            if (i == 1) push_done(3, 1);
            cyc(3, 1, 0, 0, 0);
        end
        cyc(3, 0, 0, 0, 0);
        chk("ch3_idx", 64'(block_idx[3*IDX_W +: IDX_W]), 64'd1);
        chk("ch3_busy", 64'(busy[3]), 64'd0);

        // ---------------- illegal lengths, clr_err ----------------
        cyc(0, 0, 0, 0, 1);
        chk("clr_err0", 64'(err[0]), 64'd0);
        chk("clr_drop0", 64'(drop_cnt[0 +: 16]), 64'd0);
        cyc(0, 0, 1, 0, 0);
        chk("len0_err", 64'(err[0]), 64'd1);
        chk("len0_busy", 64'(busy[0]), 64'd0);
        cyc(0, 0, 0, 0, 1);
        chk("clr_err1", 64'(err[0]), 64'd0);
        cyc(0, 0, 1, BSM + 1, 0);
        chk("lenmax_err", 64'(err[0]), 64'd1);
        chk("lenmax_busy", 64'(busy[0]), 64'd0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);   // drop coincides with clear
        chk("clr_vs_drop_err", 64'(err[0]), 64'd1);
`ifdef BLOCK_SEQ_DROP_CNT_EN
        chk("clr_vs_drop_cnt", 64'(drop_cnt[0 +: 16]), 64'd1);
`else
        chk("clr_vs_drop_cnt", 64'(drop_cnt[0 +: 16]), 64'd0);
`endif
        chk("other_err", 64'(err[3:1]), 64'd0);

        // ---------------- async reset mid-block ----------------
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 3, 0);
        push_wr(0, 0);
        cyc(0, 1, 0, 0, 0);
        push_wr(0, 1);
        cyc(0, 1, 0, 0, 0);
        chk("pre_rst_ptr", 64'(wr_ptr[0 +: PTR_W]), 64'd2);
        push_wr(0, 2);
        cyc(0, 1, 0, 0, 0);   // last beat; done now registered
        rst_n = 1'b0;
        #1;
        chk("arst_done", 64'(block_done), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_wr_en", 64'(wr_en), 64'd0);
        chk("arst_ptr", 64'(wr_ptr), 64'd0);
        chk("arst_idx", block_idx, 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_drop", drop_cnt, 64'd0);
        auto_restart = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #6;

        chk("wr_q_left", 64'(wr_q.size()), 64'd0);
        chk("done_q_left", 64'(done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
